// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - one-word-buffered parallel-to-serial stage feeding the 1101 detector input x
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LOAD = CW'(WIDTH - 1);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
  logic par, par_nx;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           state, state_nx;
  logic [WIDTH-1:0] hold, shreg, shreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             hold_full, accept, transfer, last_cycle;
  logic             x_nx, word_done_nx;

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign din_ready = !hold_full;
  assign busy      = (state != S_IDLE) || hold_full;
  assign accept    = din_valid && !hold_full;

`ifdef BIT_SERIALIZER_PARITY_EN
  assign last_cycle = (state == S_PARITY);
`else
  assign last_cycle = (state == S_SHIFT) && (cnt == '0);
`endif

  // Reloading on the last serial cycle keeps consecutive words gapless.
  assign transfer = hold_full && ((state == S_IDLE) || last_cycle);

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    shreg_nx     = shreg;
    x_nx         = IDLE_BIT;
    word_done_nx = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_nx       = par;
`endif
    if (transfer) begin
      state_nx = S_SHIFT;
      cnt_nx   = LOAD;
      shreg_nx = hold;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_nx   = ^hold;
`endif
    end else if (last_cycle) begin
      state_nx = S_IDLE;
    end else if ((state == S_SHIFT) && (cnt != '0)) begin
      cnt_nx   = cnt - CW'(1);
      shreg_nx = shift_word(shreg);
`ifdef BIT_SERIALIZER_PARITY_EN
    end else if (state == S_SHIFT) begin
      state_nx = S_PARITY;
`endif
    end

    // Outputs are precomputed from the next state so x/x_valid/word_done are plain flops.
    case (state_nx)
      S_SHIFT: begin
        x_nx = lead_bit(shreg_nx);
`ifndef BIT_SERIALIZER_PARITY_EN
        word_done_nx = (cnt_nx == '0);
`endif
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      S_PARITY: begin
        x_nx         = par_nx;
        word_done_nx = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      x         <= IDLE_BIT;
      x_valid   <= 1'b0;
      word_done <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      cnt       <= cnt_nx;
      x         <= x_nx;
      x_valid   <= (state_nx != S_IDLE);
      word_done <= word_done_nx;
`ifdef BIT_SERIALIZER_PARITY_EN
      par       <= par_nx;
`endif
      if (accept) begin
        hold      <= din;
        hold_full <= 1'b1;
      end else if (transfer) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - scoreboard bench for bit_serializer, MSB-first and LSB-first instances
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WL = 8 + PAR;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din_m = '0, din_l = '0;
  logic       vld_m = 1'b0, vld_l = 1'b0;
  logic       rdy_m, x_m, xv_m, wd_m, busy_m;
  logic       rdy_l, x_l, xv_l, wd_l, busy_l;

  exp_t q_m[$];
  exp_t q_l[$];
  int   n_vec = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   run_m = 0, last_run_m = 0, run_l = 0, last_run_l = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .din(din_m), .din_valid(vld_m), .din_ready(rdy_m),
    .x(x_m), .x_valid(xv_m), .word_done(wd_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(vld_l), .din_ready(rdy_l),
    .x(x_l), .x_valid(xv_l), .word_done(wd_l), .busy(busy_l)
  );

  // Scoreboard: every serial cycle of each instance is checked against queued bits.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      n_vec++;
      if (xv_m) begin
        run_m++;
        if (q_m.size() == 0) begin
          n_fail++;
          $display("FAIL msb_unexpected_bit: x_valid=1 with no pending bits");
        end else begin
          e = q_m.pop_front();
          if ({x_m, wd_m} !== {e.b, e.last}) begin
            n_fail++;
            $display("FAIL msb_bit: {x,word_done}=%b required %b", {x_m, wd_m}, {e.b, e.last});
          end
        end
      end else begin
        if (run_m > 0) begin last_run_m = run_m; run_m = 0; end
        if ({x_m, wd_m} !== 2'b00) begin
          n_fail++;
          $display("FAIL msb_idle: {x,word_done}=%b required 00", {x_m, wd_m});
        end
      end
      n_vec++;
      if (xv_l) begin
        run_l++;
        if (q_l.size() == 0) begin
          n_fail++;
          $display("FAIL lsb_unexpected_bit: x_valid=1 with no pending bits");
        end else begin
          e = q_l.pop_front();
          if ({x_l, wd_l} !== {e.b, e.last}) begin
            n_fail++;
            $display("FAIL lsb_bit: {x,word_done}=%b required %b", {x_l, wd_l}, {e.b, e.last});
          end
        end
      end else begin
        if (run_l > 0) begin last_run_l = run_l; run_l = 0; end
        if ({x_l, wd_l} !== 2'b00) begin
          n_fail++;
          $display("FAIL lsb_idle: {x,word_done}=%b required 00", {x_l, wd_l});
        end
      end
    end
  end

  task automatic send(input bit lane, input logic [7:0] d, input bit keep);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    if (lane) begin din_l = d; vld_l = 1'b1; end
    else begin din_m = d; vld_m = 1'b1; end
    while (!(lane ? rdy_l : rdy_m) && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (!(lane ? rdy_l : rdy_m)) begin
      n_fail++;
      $display("FAIL accept_timeout: din_ready=0 required 1");
    end else begin
      for (int i = 0; i < 8; i++) begin
        e.b    = lane ? d[i] : d[7-i];
        e.last = (i == 7) && (PAR == 0);
        if (lane) q_l.push_back(e); else q_m.push_back(e);
      end
      if (PAR != 0) begin
        e.b    = ^d;
        e.last = 1'b1;
        if (lane) q_l.push_back(e); else q_m.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      if (lane) vld_l = 1'b0; else vld_m = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((xv_m || busy_m || xv_l || busy_l) && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (xv_m || busy_m || xv_l || busy_l) begin
      n_fail++;
      $display("FAIL idle_timeout: busy_m=%b busy_l=%b required 0", busy_m, busy_l);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({x_m, xv_m, wd_m, rdy_m, busy_m} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_msb: {x,x_valid,word_done,din_ready,busy}=%b required 00010",
               {x_m, xv_m, wd_m, rdy_m, busy_m});
    end
    n_vec++;
    if ({x_l, xv_l, wd_l, rdy_l, busy_l} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_lsb: {x,x_valid,word_done,din_ready,busy}=%b required 00010",
               {x_l, xv_l, wd_l, rdy_l, busy_l});
    end
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] sh4;
    int         first_z;
    logic       ev, ed;
    sh4     = '0;
    first_z = 0;
    send(1'b0, 8'hD5, 1'b0);
    @(negedge clk);
    n_vec++;
    if (xv_m !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: x_valid=%b in accept cycle required 0", xv_m);
    end
    for (int k = 1; k <= WL + 1; k++) begin
      @(negedge clk);
      ev = (k <= WL);
      ed = (k == WL);
      n_vec++;
      if ({xv_m, wd_m} !== {ev, ed}) begin
        n_fail++;
        $display("FAIL single_timing: cycle N+%0d {x_valid,word_done}=%b required %b",
                 k, {xv_m, wd_m}, {ev, ed});
      end
      if (xv_m && k <= 8) begin
        sh4 = {sh4[2:0], x_m};
        if (sh4 == 4'b1101 && first_z == 0) first_z = k;
      end
    end
    n_vec++;
    if (first_z !== 4) begin
      n_fail++;
      $display("FAIL single_detector_z: first 1101 at bit %0d required 4", first_z);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    send(1'b0, 8'hD5, 1'b1);
    send(1'b0, 8'hA6, 1'b1);
    n_vec++;
    if (rdy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready_drop: din_ready=%b required 0", rdy_m);
    end
    vld_m = 1'b0;
    for (int t = 0; t < 40 && seen < 2; t++) begin
      @(negedge clk);
      if (seen == 1) begin
        seen = 2;
        n_vec++;
        if (rdy_m !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready_rise: din_ready=%b after transfer required 1", rdy_m);
        end
      end else if (wd_m && seen == 0) begin
        seen = 1;
        n_vec++;
        if (rdy_m !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ready_hold: din_ready=%b in last cycle of word 1 required 0", rdy_m);
        end
      end
    end
    n_vec++;
    if (seen != 2) begin
      n_fail++;
      $display("FAIL b2b_word_done_timeout: stage %0d required 2", seen);
    end
    wait_idle();
    n_vec++;
    if (last_run_m != 2 * WL) begin
      n_fail++;
      $display("FAIL b2b_gapless: run of %0d x_valid cycles required %0d", last_run_m, 2 * WL);
    end
  endtask

  task automatic test_lsb_first();
    send(1'b1, 8'h0B, 1'b0);
    wait_idle();
    n_vec++;
    if (last_run_l != WL) begin
      n_fail++;
      $display("FAIL lsb_length: run of %0d cycles required %0d", last_run_l, WL);
    end
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 8'($urandom_range(0, 255)), 1'b1);
      send(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    end
    vld_m = 1'b0;
    vld_l = 1'b0;
    wait_idle();
    n_vec++;
    if (last_run_m != 6 * WL || last_run_l != 6 * WL) begin
      n_fail++;
      $display("FAIL stream_gapless: runs %0d/%0d required %0d", last_run_m, last_run_l, 6 * WL);
    end
  endtask

  task automatic test_reset_mid_word();
    bit seen;
    seen = 1'b0;
    send(1'b0, 8'hFF, 1'b0);
    send(1'b0, 8'h3C, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    n_vec++;
    if ({xv_m, dut_m.hold_full} !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_setup: {x_valid,hold_full}=%b required 11", {xv_m, dut_m.hold_full});
    end
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    q_m.delete();
    run_m = 0;
    n_vec++;
    if ({x_m, xv_m, wd_m, rdy_m, busy_m, dut_m.hold_full} !== 6'b000100) begin
      n_fail++;
      $display("FAIL midrst_async: {x,x_valid,word_done,din_ready,busy,hold_full}=%b required 000100",
               {x_m, xv_m, wd_m, rdy_m, busy_m, dut_m.hold_full});
    end
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (xv_m || busy_m) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_quiet: activity=%b after release required 0", seen);
    end
  endtask

`ifdef BIT_SERIALIZER_PARITY_EN
  task automatic test_parity();
    send(1'b0, 8'hD5, 1'b1);
    send(1'b0, 8'h3C, 1'b1);
    vld_m = 1'b0;
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        n_vec++;
        if ({xv_m, x_m, wd_m} !== 3'b111) begin
          n_fail++;
          $display("FAIL parity_bit: {x_valid,x,word_done}=%b required 111", {xv_m, x_m, wd_m});
        end
      end
      if (k == 10) begin
        n_vec++;
        if ({xv_m, x_m, wd_m} !== 3'b100) begin
          n_fail++;
          $display("FAIL parity_next_word: {x_valid,x,word_done}=%b required 100", {xv_m, x_m, wd_m});
        end
      end
    end
    wait_idle();
  endtask
`endif

  task automatic test_drain();
    n_vec++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending bits %0d/%0d required 0", q_m.size(), q_l.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_random_stream();
    test_reset_mid_word();
`ifdef BIT_SERIALIZER_PARITY_EN
    test_parity();
`endif
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
